// File: rtl/pong_game_ctrl_pkg.sv
// Shared constants, encodings and helpers for the pong game sequencer and its renderer.
package pong_game_ctrl_pkg;

    localparam logic [7:0] XMAX        = 8'd255;
    localparam logic [7:0] YMAX        = 8'd191;
    localparam logic [7:0] PADDLE_H    = 8'd32;
    localparam logic [7:0] SPEED       = 8'd2;
    localparam logic [3:0] WIN_SCORE   = 4'd9;
    localparam logic [7:0] SERVE_TICKS = 8'd60;

    localparam logic [7:0] X_CENTRE = XMAX >> 1;
    localparam logic [7:0] Y_CENTRE = YMAX >> 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'd0,
        WIN_LEFT  = 2'd1,
        WIN_RIGHT = 2'd2
    } winner_e;

    // DEC = left / up, INC = right / down
    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_e;

    // Paddle window test done in 9 bits so a window near 255 does not wrap.
    function automatic logic in_window(input logic [7:0] pos, input logic [7:0] y);
        logic [8:0] top;
        logic [8:0] yy;
        top = {1'b0, pos} + {1'b0, PADDLE_H};
        yy  = {1'b0, y};
        return (yy >= {1'b0, pos}) && (yy < top);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_SCORE) ? WIN_SCORE : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Player/renderer side of the pong game sequencer: paddle and control inputs, ball/score outputs.
interface pong_game_ctrl_if;
    logic       tick;
    logic       start;
    logic [7:0] p1_pos;
    logic [7:0] p2_pos;
    logic [7:0] ball_x;
    logic [7:0] ball_y;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [2:0] state;
    logic       scored;
    logic [1:0] winner;

    modport master (
        output tick, start, p1_pos, p2_pos,
        input  ball_x, ball_y, score1, score2, state, scored, winner
    );

    modport slave (
        input  tick, start, p1_pos, p2_pos,
        output ball_x, ball_y, score1, score2, state, scored, winner
    );
endinterface

// File: rtl/pong_ball_axis.sv
// One ball axis: proposes the next coordinate and flags when this step reaches an edge.
module pong_ball_axis
    import pong_game_ctrl_pkg::*;
(
    input  logic [7:0] pos_i,
    input  dir_e       dir_i,
    input  logic [7:0] step_i,
    input  logic [7:0] max_i,
    input  logic       tick_i,
    output logic [7:0] next_pos_o,
    output logic       edge_lo_o,
    output logic       edge_hi_o
);

    logic [8:0] sum_s;

    assign sum_s     = {1'b0, pos_i} + {1'b0, step_i};
    assign edge_lo_o = tick_i && (dir_i == DIR_DEC) && (pos_i <= step_i);
    assign edge_hi_o = tick_i && (dir_i == DIR_INC) && (sum_s >= {1'b0, max_i});

    // Edge hits clamp to the boundary; otherwise step in the current direction.
    always_comb begin
        next_pos_o = pos_i;
        if (!tick_i) begin
            next_pos_o = pos_i;
        end else if (edge_hi_o) begin
            next_pos_o = max_i;
        end else if (edge_lo_o) begin
            next_pos_o = 8'd0;
        end else if (dir_i == DIR_INC) begin
            next_pos_o = sum_s[7:0];
        end else begin
            next_pos_o = pos_i - step_i;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/rally/point/game-over FSM, ball registers, scores and paddle tests.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    pong_game_ctrl_if.slave bus
);

    state_e     state_q,  state_d;
    logic [7:0] x_q,      x_d;
    logic [7:0] y_q,      y_d;
    dir_e       dx_q,     dx_d;
    dir_e       dy_q,     dy_d;
    logic [7:0] cnt_q,    cnt_d;
    logic       tog_q,    tog_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    winner_e    winner_q, winner_d;
    winner_e    scorer_q, scorer_d;
    logic       scored_q, scored_d;

    logic       play_tick_s;
    logic [7:0] x_next_s, y_next_s;
    logic       x_lo_s, x_hi_s, y_lo_s, y_hi_s;
    logic       p1_hit_s, p2_hit_s;
    logic [3:0] scorer_score_s;

    assign play_tick_s    = (state_q == ST_PLAY) && bus.tick;
    assign p1_hit_s       = in_window(bus.p1_pos, y_q);
    assign p2_hit_s       = in_window(bus.p2_pos, y_q);
    assign scorer_score_s = (scorer_q == WIN_LEFT) ? score1_q : score2_q;

    pong_ball_axis u_axis_x (
        .pos_i      (x_q),
        .dir_i      (dx_q),
        .step_i     (SPEED),
        .max_i      (XMAX),
        .tick_i     (play_tick_s),
        .next_pos_o (x_next_s),
        .edge_lo_o  (x_lo_s),
        .edge_hi_o  (x_hi_s)
    );

    pong_ball_axis u_axis_y (
        .pos_i      (y_q),
        .dir_i      (dy_q),
        .step_i     (SPEED),
        .max_i      (YMAX),
        .tick_i     (play_tick_s),
        .next_pos_o (y_next_s),
        .edge_lo_o  (y_lo_s),
        .edge_hi_o  (y_hi_s)
    );

    // Next-state logic for the game FSM and every datapath register.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        cnt_d    = cnt_q;
        tog_d    = tog_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        scorer_d = scorer_q;
        scored_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = WIN_NONE;
                    cnt_d    = 8'd0;
                    x_d      = X_CENTRE;
                    y_d      = Y_CENTRE;
                    state_d  = ST_SERVE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SERVE: begin
                if (bus.tick) begin
                    if (cnt_q == SERVE_TICKS - 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_PLAY: begin
                if (bus.tick) begin
                    y_d = y_next_s;
                    if (y_hi_s) begin
                        dy_d = DIR_DEC;
                    end else if (y_lo_s) begin
                        dy_d = DIR_INC;
                    end else begin
                        dy_d = dy_q;
                    end
                    // A miss leaves x where it was; the ball is recentred on leaving POINT.
                    if (x_lo_s) begin
                        if (p1_hit_s) begin
                            x_d  = x_next_s;
                            dx_d = DIR_INC;
                        end else begin
                            state_d  = ST_POINT;
                            scored_d = 1'b1;
                            scorer_d = WIN_RIGHT;
                            score2_d = sat_inc(score2_q);
                        end
                    end else if (x_hi_s) begin
                        if (p2_hit_s) begin
                            x_d  = x_next_s;
                            dx_d = DIR_DEC;
                        end else begin
                            state_d  = ST_POINT;
                            scored_d = 1'b1;
                            scorer_d = WIN_LEFT;
                            score1_d = sat_inc(score1_q);
                        end
                    end else begin
                        x_d = x_next_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_POINT: begin
                x_d = X_CENTRE;
                y_d = Y_CENTRE;
                if (scorer_score_s == WIN_SCORE) begin
                    winner_d = scorer_q;
                    state_d  = ST_OVER;
                end else begin
                    dx_d    = (scorer_q == WIN_LEFT) ? DIR_INC : DIR_DEC;
                    dy_d    = dir_e'(tog_q);
                    tog_d   = ~tog_q;
                    cnt_d   = 8'd0;
                    state_d = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            x_q      <= X_CENTRE;
            y_q      <= Y_CENTRE;
            dx_q     <= DIR_INC;
            dy_q     <= DIR_INC;
            cnt_q    <= 8'd0;
            tog_q    <= 1'b0;
            score1_q <= 4'd0;
            score2_q <= 4'd0;
            winner_q <= WIN_NONE;
            scorer_q <= WIN_NONE;
            scored_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            cnt_q    <= cnt_d;
            tog_q    <= tog_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
            scorer_q <= scorer_d;
            scored_q <= scored_d;
        end
    end

    assign bus.ball_x = x_q;
    assign bus.ball_y = y_q;
    assign bus.score1 = score1_q;
    assign bus.score2 = score2_q;
    assign bus.state  = state_q;
    assign bus.scored = scored_q;
    assign bus.winner = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized scoreboard bench for pong_game_ctrl against a velocity-based game model.
module tb_pong_game_ctrl;

    typedef struct {
        int st;
        int x;
        int y;
        int s1;
        int s2;
        int sc;
        int w;
    } exp_t;

    localparam int S   = 2;
    localparam int XM  = 255;
    localparam int YM  = 191;
    localparam int PH  = 32;
    localparam int WS  = 9;
    localparam int STK = 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // model state: 0 idle, 1 serve, 2 play, 3 point, 4 over; velocities are signed steps
    int m_st, m_x, m_y, m_vx, m_vy, m_cnt, m_tog, m_s1, m_s2, m_win, m_sc, m_scorer;

    task automatic model_reset();
        m_st = 0; m_x = XM / 2; m_y = YM / 2; m_vx = S; m_vy = S;
        m_cnt = 0; m_tog = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_sc = 0; m_scorer = 0;
    endtask

    function automatic bit on_paddle(input int p, input int y);
        return (p <= y) && (y < p + PH);
    endfunction

    task automatic model_step(input bit r, input bit t, input bit s, input int p1, input int p2);
        int ny;
        int sc_val;
        if (!r) begin
            model_reset();
            return;
        end
        m_sc = 0;
        case (m_st)
            0, 4: if (s) begin
                m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0;
                m_x = XM / 2; m_y = YM / 2; m_st = 1;
            end
            1: if (t) begin
                if (m_cnt == STK - 1) begin m_cnt = 0; m_st = 2; end
                else m_cnt++;
            end
            2: if (t) begin
                if (m_vy > 0 && m_y + S >= YM) begin ny = YM; m_vy = -S; end
                else if (m_vy < 0 && m_y <= S) begin ny = 0; m_vy = S; end
                else ny = m_y + m_vy;
                if (m_vx < 0 && m_x <= S) begin
                    if (on_paddle(p1, m_y)) begin m_x = 0; m_vx = S; end
                    else begin m_st = 3; m_sc = 1; m_scorer = 2; if (m_s2 < WS) m_s2++; end
                end else if (m_vx > 0 && m_x + S >= XM) begin
                    if (on_paddle(p2, m_y)) begin m_x = XM; m_vx = -S; end
                    else begin m_st = 3; m_sc = 1; m_scorer = 1; if (m_s1 < WS) m_s1++; end
                end else begin
                    m_x = m_x + m_vx;
                end
                m_y = ny;
            end
            3: begin
                m_x = XM / 2; m_y = YM / 2;
                sc_val = (m_scorer == 1) ? m_s1 : m_s2;
                if (sc_val == WS) begin
                    m_win = m_scorer; m_st = 4;
                end else begin
                    m_vx  = (m_scorer == 1) ? S : -S;
                    m_vy  = (m_tog != 0) ? S : -S;
                    m_tog = 1 - m_tog;
                    m_cnt = 0;
                    m_st  = 1;
                end
            end
            default: ;
        endcase
    endtask

    function automatic int choose_pad(input int y);
        case ($urandom_range(0, 5))
            0: return int'($urandom_range(0, 255));
            1: return y & 255;
            2: return (y - (PH - 1)) & 255;
            3: return (y - PH) & 255;
            4: return (y + 1) & 255;
            default: return 240;
        endcase
    endfunction

    // One stimulus cycle: drive after the falling edge, advance the model, queue the expectation.
    task automatic drive_cycle(input bit r, input bit t, input bit s, input int p1, input int p2,
                               input bit glitch);
        exp_t e;
        @(negedge clk);
        rst_n      = r;
        bus.tick   = t;
        bus.start  = s;
        bus.p1_pos = p1[7:0];
        bus.p2_pos = p2[7:0];
        model_step(r, t, s, p1, p2);
        e.st = m_st; e.x = m_x; e.y = m_y; e.s1 = m_s1; e.s2 = m_s2; e.sc = m_sc; e.w = m_win;
        exp_q.push_back(e);
        if (glitch) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
        end
    endtask

    // Monitor: compare DUT outputs just after every edge that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (int'(bus.state) != e.st || int'(bus.ball_x) != e.x || int'(bus.ball_y) != e.y ||
                    int'(bus.score1) != e.s1 || int'(bus.score2) != e.s2 ||
                    int'(bus.scored) != e.sc || int'(bus.winner) != e.w) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got st=%0d x=%0d y=%0d s1=%0d s2=%0d sc=%0d w=%0d want st=%0d x=%0d y=%0d s1=%0d s2=%0d sc=%0d w=%0d",
                             $time, bus.state, bus.ball_x, bus.ball_y, bus.score1, bus.score2,
                             bus.scored, bus.winner, e.st, e.x, e.y, e.s1, e.s2, e.sc, e.w);
                end
            end
        end
    end

    initial begin
        bit r, t, s, g;
        bus.tick = 1'b0; bus.start = 1'b0; bus.p1_pos = 8'd0; bus.p2_pos = 8'd0;
        model_reset();

        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        repeat (70) drive_cycle(1'b1, ($urandom_range(0, 3) != 0), 1'b0, 100, 100, 1'b0);

        for (int i = 0; i < 40000; i++) begin
            r = ($urandom_range(0, 4999) != 0);
            t = ($urandom_range(0, 9) < 8);
            s = ($urandom_range(0, 199) == 0);
            if (m_st == 0 || m_st == 4) s = s || ($urandom_range(0, 19) == 0);
            if (m_st == 2 && $urandom_range(0, 2999) == 0) begin
                r = 1'b0; t = 1'b1; s = 1'b1;
            end
            g = r && ($urandom_range(0, 299) == 0);
            drive_cycle(r, t, s, choose_pad(m_y), choose_pad(m_y), g);
        end

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
